// File: rtl/iq_sync_fifo_pkg.sv
// Shared constants and types for the I/Q sample FIFO between the LVDS deserializer and SMI readout.
package iq_fifo_pkg;

    localparam int IQ_DATA_WIDTH      = 32;
    localparam int IQ_FIFO_ADDR_WIDTH = 8;

    // One complex sample: I in the upper half, Q in the lower half.
    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } iq_sample_t;

    typedef logic [IQ_FIFO_ADDR_WIDTH:0] iq_ptr_t;

    function automatic iq_sample_t iq_pack(input logic [15:0] i, input logic [15:0] q);
        iq_sample_t s;
        s.i = i;
        s.q = q;
        return s;
    endfunction

endpackage

// File: rtl/iq_sync_fifo_if.sv
// Push/pull bus of the I/Q FIFO; the occupancy signal exists only with IQ_SYNC_FIFO_LEVEL_EN.
interface iq_sync_fifo_if import iq_fifo_pkg::*; ();

    logic                          wr_en_i;
    logic [IQ_DATA_WIDTH-1:0]      wr_data_i;
    logic                          rd_en_i;
    logic [IQ_DATA_WIDTH-1:0]      rd_data_o;
    logic                          full_o;
    logic                          empty_o;
`ifdef IQ_SYNC_FIFO_LEVEL_EN
    logic [IQ_FIFO_ADDR_WIDTH:0]   fill_level_o;
`endif

    modport master (
        output wr_en_i, wr_data_i, rd_en_i,
`ifdef IQ_SYNC_FIFO_LEVEL_EN
        input  fill_level_o,
`endif
        input  rd_data_o, full_o, empty_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_en_i,
`ifdef IQ_SYNC_FIFO_LEVEL_EN
        output fill_level_o,
`endif
        output rd_data_o, full_o, empty_o
    );

endinterface

// File: rtl/iq_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port, shaped to infer SB_RAM40_4K.
module iq_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // No reset on the read register so the block RAM output latch can absorb it.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iq_sync_fifo.sv
// Single-clock I/Q sample FIFO with wrap-bit pointers; IQ_SYNC_FIFO_LEVEL_EN adds the fill_level_o output.
module iq_sync_fifo import iq_fifo_pkg::*; #(
    parameter int DATA_WIDTH = IQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = IQ_FIFO_ADDR_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    iq_sync_fifo_if.slave bus
);

    typedef logic [ADDR_WIDTH:0] ptr_t;

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic                  rd_zero_q, rd_zero_d;
    logic                  full, empty;
    logic                  wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Flags come from registered pointers only, so accepts see the pre-edge flag values.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        wr_accept = bus.wr_en_i && !full;
        rd_accept = bus.rd_en_i && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_zero_d = rd_zero_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + ptr_t'(1);
            rd_zero_d = 1'b0;
        end
    end

    // rd_zero_q masks the unreset RAM read register to zero until the first accepted read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_zero_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    iq_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_accept && !rst_i),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.wr_data_i),
        .re_i    (rd_accept && !rst_i),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.rd_data_o = rd_zero_q ? '0 : ram_rdata;
    assign bus.full_o    = full;
    assign bus.empty_o   = empty;

`ifdef IQ_SYNC_FIFO_LEVEL_EN
    assign bus.fill_level_o = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_iq_sync_fifo.sv
// Randomised scoreboard bench for iq_sync_fifo; also checks fill_level_o when IQ_SYNC_FIFO_LEVEL_EN is defined.
module tb_iq_sync_fifo;
    import iq_fifo_pkg::*;

    localparam int DEPTH = 2**IQ_FIFO_ADDR_WIDTH;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    int   wordsAccepted;
    bit   monEn;

    logic [31:0] modelQ[$];
    logic [31:0] expQ[$];
    logic [31:0] holdVal;

    iq_sync_fifo_if fifoBus();

    iq_sync_fifo dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (fifoBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] data, input logic rd);
        fifoBus.wr_en_i   = wr;
        fifoBus.wr_data_i = data;
        fifoBus.rd_en_i   = rd;
        @(negedge clk);
    endtask

    // Reference model: a plain queue of stored samples, updated with the accept rules at each rising edge.
    always @(posedge clk) begin
        logic wrAcc;
        logic rdAcc;
        logic [31:0] d;
        if (rst) begin
            modelQ.delete();
            expQ.delete();
            holdVal = '0;
        end else begin
            wrAcc = (fifoBus.wr_en_i === 1'b1) && (modelQ.size() < DEPTH);
            rdAcc = (fifoBus.rd_en_i === 1'b1) && (modelQ.size() > 0);
            if (rdAcc) begin
                d = modelQ.pop_front();
                expQ.push_back(d);
                holdVal = d;
            end
            if (wrAcc) begin
                modelQ.push_back(fifoBus.wr_data_i);
                wordsAccepted++;
            end
        end
    end

    // Monitor: pops expected samples and checks flags against the model each falling edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (monEn) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rdData", fifoBus.rd_data_o, e);
            end else begin
                checkOutput("rdHold", fifoBus.rd_data_o, holdVal);
            end
            checkOutput("empty", 32'(fifoBus.empty_o), 32'(modelQ.size() == 0));
            checkOutput("full", 32'(fifoBus.full_o), 32'(modelQ.size() == DEPTH));
`ifdef IQ_SYNC_FIFO_LEVEL_EN
            checkOutput("level", 32'(fifoBus.fill_level_o), 32'(modelQ.size()));
`endif
        end
    end

    initial begin
        logic [31:0] v;
        bit resetDone;
        testsRun          = 0;
        testsFailed       = 0;
        wordsAccepted     = 0;
        monEn             = 1'b0;
        rst               = 1'b1;
        fifoBus.wr_en_i   = 1'b0;
        fifoBus.wr_data_i = '0;
        fifoBus.rd_en_i   = 1'b0;

        // Reset held for two rising edges.
        @(negedge clk);
        monEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstEmpty", 32'(fifoBus.empty_o), 32'd1);
        checkOutput("rstFull", 32'(fifoBus.full_o), 32'd0);
        checkOutput("rstRdData", fifoBus.rd_data_o, 32'd0);
`ifdef IQ_SYNC_FIFO_LEVEL_EN
        checkOutput("rstLevel", 32'(fifoBus.fill_level_o), 32'd0);
`endif

        // Single write then single read.
        applyStimulus(1'b1, 32'h1234_5678, 1'b0);
        checkOutput("t2Empty0", 32'(fifoBus.empty_o), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t2RdData", fifoBus.rd_data_o, 32'h1234_5678);
        checkOutput("t2Empty1", 32'(fifoBus.empty_o), 32'd1);

        // Fill to capacity, overflow attempt, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0);
        end
        checkOutput("t3Full", 32'(fifoBus.full_o), 32'd1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("t3FullAfterDrop", 32'(fifoBus.full_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("t3Drain", fifoBus.rd_data_o, 32'(i));
        end
        checkOutput("t3EmptyEnd", 32'(fifoBus.empty_o), 32'd1);

        // Steady state at level 10 with simultaneous push and pull.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, $urandom, 1'b1);
            checkOutput("t4NotEmpty", 32'(fifoBus.empty_o), 32'd0);
            checkOutput("t4NotFull", 32'(fifoBus.full_o), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkOutput("t4EmptyEnd", 32'(fifoBus.empty_o), 32'd1);

        // Read on empty, then write and read together on empty.
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b1);
        checkOutput("t5Empty0", 32'(fifoBus.empty_o), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t5RdData", fifoBus.rd_data_o, 32'hA5A5_A5A5);

        // Random push/pull of 600 words with a reset after word 300.
        wordsAccepted = 0;
        resetDone     = 1'b0;
        for (int cyc = 0; cyc < 6000 && wordsAccepted < 600; cyc++) begin
            if (!resetDone && wordsAccepted >= 300) begin
                rst = 1'b1;
                applyStimulus(1'b1, $urandom, 1'b1);
                rst = 1'b0;
                resetDone = 1'b1;
                checkOutput("t6RstEmpty", 32'(fifoBus.empty_o), 32'd1);
                checkOutput("t6RstRdData", fifoBus.rd_data_o, 32'd0);
            end else begin
                v = 32'(iq_pack(16'($urandom), 16'($urandom)));
                applyStimulus($urandom_range(0, 3) != 0, v, $urandom_range(0, 1) == 1);
            end
        end
        checkOutput("t6WordsDone", 32'(wordsAccepted >= 600), 32'd1);
        for (int i = 0; i < DEPTH + 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkOutput("t6EmptyEnd", 32'(fifoBus.empty_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        monEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
